// File: rtl/ula_result_queue.sv
// ALU result FIFO: captures ULA results and presents one entry per bus request.
// Optional out_zero_o/out_neg_o flags are built only when ULA_RESULT_FLAGS_EN is defined.
module ula_result_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [WIDTH-1:0]           ula_result_i,
    input  logic                       grab_i,
    input  logic                       store_data_bus_i,
    input  logic                       clear_overflow_i,
    output logic [WIDTH-1:0]           out_o,
    output logic                       out_valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
`ifdef ULA_RESULT_FLAGS_EN
    output logic                       out_zero_o,
    output logic                       out_neg_o,
`endif
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             is_empty, is_full;
    logic             pop_acc, push_acc, drop;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // A push into a full queue is legal only when the same edge frees a slot.
    assign pop_acc  = store_data_bus_i && !is_empty;
    assign push_acc = grab_i && (!is_full || pop_acc);
    assign drop     = grab_i && !push_acc;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_d       = '0;
        out_valid_d = 1'b0;
        overflow_d  = overflow_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_acc) begin
            out_d       = mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + AW'(1);
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clock_i) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= ula_result_i;
        end
    end

`ifdef ULA_RESULT_FLAGS_EN
    logic out_zero_q, out_neg_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            out_zero_q <= 1'b0;
            out_neg_q  <= 1'b0;
        end else begin
            out_zero_q <= pop_acc && (mem_q[rd_ptr_q] == '0);
            out_neg_q  <= pop_acc && mem_q[rd_ptr_q][WIDTH-1];
        end
    end

    assign out_zero_o = out_zero_q;
    assign out_neg_o  = out_neg_q;
`endif

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign count_o     = count_q;
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_ula_result_queue.sv
// Bench for ula_result_queue: directed vector table, async-reset sequence, and
// randomized traffic checked against a queue-based reference model.
module tb_ula_result_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] ula_result = '0;
    logic             grab = 1'b0;
    logic             store_data_bus = 1'b0;
    logic             clear_overflow = 1'b0;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [2:0]       count;
    logic             empty, full, overflow;
`ifdef ULA_RESULT_FLAGS_EN
    logic             out_zero, out_neg;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ula_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .ula_result_i     (ula_result),
        .grab_i           (grab),
        .store_data_bus_i (store_data_bus),
        .clear_overflow_i (clear_overflow),
        .out_o            (out),
        .out_valid_o      (out_valid),
        .count_o          (count),
        .empty_o          (empty),
        .full_o           (full),
`ifdef ULA_RESULT_FLAGS_EN
        .out_zero_o       (out_zero),
        .out_neg_o        (out_neg),
`endif
        .overflow_o       (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       g, s, c;
        logic [7:0] d;
        logic [7:0] eo;
        logic       ev;
        int         ec;
        logic       eov;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic g, input logic s, input logic c, input logic [7:0] d,
                       input logic [7:0] eo, input logic ev, input int ec, input logic eov);
        vec_t v;
        v.g = g; v.s = s; v.c = c; v.d = d;
        v.eo = eo; v.ev = ev; v.ec = ec; v.eov = eov;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] eo, input logic ev,
                             input int ec, input logic eov);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".count"}, 32'(count), 32'(ec));
        chk({tag, ".empty"}, 32'(empty), 32'(ec == 0));
        chk({tag, ".full"}, 32'(full), 32'(ec == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eov));
`ifdef ULA_RESULT_FLAGS_EN
        chk({tag, ".out_zero"}, 32'(out_zero), 32'(ev && (eo == 8'h00)));
        chk({tag, ".out_neg"}, 32'(out_neg), 32'(ev && eo[7]));
`endif
    endtask

    // Called at posedge+1: drive inputs, advance one edge, land at posedge+1.
    task automatic apply(input logic g, input logic s, input logic c, input logic [7:0] d);
        grab = g; store_data_bus = s; clear_overflow = c; ula_result = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        grab = 0; store_data_bus = 0; clear_overflow = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Reference model: plain queue plus sticky flag.
    logic [7:0] mq[$];
    logic       m_ovf;
    logic [7:0] m_out;
    logic       m_valid;

    task automatic model_step(input logic g, input logic s, input logic c, input logic [7:0] d);
        logic pop_ok, push_ok;
        pop_ok  = s && (mq.size() > 0);
        push_ok = g && ((mq.size() < DEPTH) || pop_ok);
        m_out   = pop_ok ? mq[0] : 8'h00;
        m_valid = pop_ok;
        if (pop_ok)  void'(mq.pop_front());
        if (push_ok) mq.push_back(d);
        if (g && !push_ok) m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
    endtask

    initial begin
        // g s c data   exp_out valid count ovf
        add(0,1,0,8'h00, 8'h00,0,0,0);  // pop on empty
        add(1,0,0,8'h11, 8'h00,0,1,0);
        add(1,0,0,8'h22, 8'h00,0,2,0);
        add(1,0,0,8'h33, 8'h00,0,3,0);
        add(1,0,0,8'h44, 8'h00,0,4,0);
        add(1,0,0,8'h55, 8'h00,0,4,1);  // dropped
        add(0,0,1,8'h00, 8'h00,0,4,0);
        add(1,1,0,8'h66, 8'h11,1,4,0);  // full push+pop
        add(0,1,0,8'h00, 8'h22,1,3,0);
        add(0,1,0,8'h00, 8'h33,1,2,0);
        add(0,1,0,8'h00, 8'h44,1,1,0);
        add(0,1,0,8'h00, 8'h66,1,0,0);  // wrap-around
        add(0,1,0,8'h00, 8'h00,0,0,0);
        add(1,1,0,8'h77, 8'h00,0,1,0);  // no bypass
        add(0,1,0,8'h00, 8'h77,1,0,0);
        add(0,0,0,8'h00, 8'h00,0,0,0);
        add(1,0,0,8'h00, 8'h00,0,1,0);
        add(1,0,0,8'h80, 8'h00,0,2,0);
        add(1,0,0,8'h7f, 8'h00,0,3,0);
        add(1,0,0,8'h01, 8'h00,0,4,0);
        add(1,0,1,8'h99, 8'h00,0,4,1);  // drop beats clear
        add(0,0,1,8'h00, 8'h00,0,4,0);
        add(0,1,0,8'h00, 8'h00,1,3,0);
        add(0,1,0,8'h00, 8'h80,1,2,0);
        add(0,0,0,8'h00, 8'h00,0,2,0);  // idle clears bus word
        add(0,1,0,8'h00, 8'h7f,1,1,0);
        add(0,1,0,8'h00, 8'h01,1,0,0);

        do_reset();
        check_all("reset", 8'h00, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i].g, tv[i].s, tv[i].c, tv[i].d);
            check_all($sformatf("vec%0d", i), tv[i].eo, tv[i].ev, tv[i].ec, tv[i].eov);
        end

        // Asynchronous reset with three entries and a live bus word.
        apply(1,0,0,8'ha1);
        apply(1,0,0,8'ha2);
        apply(1,0,0,8'ha3);
        apply(1,0,0,8'ha4);
        apply(0,1,0,8'h00);
        check_all("pre_arst", 8'ha1, 1, 3, 0);
        grab = 0; store_data_bus = 0;
        #2 reset = 1'b1;
        #1 check_all("arst", 8'h00, 0, 0, 0);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        apply(0,1,0,8'h00);
        check_all("post_arst", 8'h00, 0, 0, 0);

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic g, s, c;
            logic [7:0] d;
            g = ($urandom_range(0, 99) < 60);
            s = ($urandom_range(0, 99) < 55);
            c = ($urandom_range(0, 99) < 8);
            d = 8'($urandom);
            if ($urandom_range(0, 15) == 0) d = 8'h00;
            model_step(g, s, c, d);
            apply(g, s, c, d);
            check_all($sformatf("rnd%0d", i), m_out, m_valid, mq.size(), m_ovf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
